// File: rtl/nvme_to_fifo_writer_pkg.sv
// rtl/nvme_to_fifo_writer_pkg.sv - shared widths, header layout and FSM states for the NVMe FIFO writer
package nvme_fifo_pkg;

  localparam int NVME_ENTRY_W   = 540;
  localparam int NVME_PAYLOAD_W = 512;
  localparam int NVME_HDR_W     = 28;
  localparam int NVME_BEAT_W    = 64;
  localparam int NVME_BEATS     = NVME_PAYLOAD_W / NVME_BEAT_W;

  localparam int HDR_OPCODE_LSB = 512;
  localparam int HDR_TAG_LSB    = 520;
  localparam int HDR_BEATS_LSB  = 532;
  localparam int HDR_LAST_BIT   = 536;
  localparam int HDR_CONT_BIT   = 537;

  typedef struct packed {
    logic [1:0]  rsvd;
    logic        cont;
    logic        last;
    logic [3:0]  beats;
    logic [11:0] tag;
    logic [7:0]  opcode;
  } nvme_fifo_hdr_t;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    WRITE
  } nvme_wr_state_e;

  function automatic logic [NVME_ENTRY_W-1:0] nvme_pack_entry(
    input nvme_fifo_hdr_t            hdr,
    input logic [NVME_PAYLOAD_W-1:0] payload
  );
    return {hdr, payload};
  endfunction

endpackage

// File: rtl/nvme_to_fifo_writer_if.sv
// rtl/nvme_to_fifo_writer_if.sv - beat stream in and FIFO write port out of the NVMe FIFO writer
interface nvme_to_fifo_writer_if;
  import nvme_fifo_pkg::*;

  logic                    s_valid;
  logic                    s_ready;
  logic [NVME_BEAT_W-1:0]  s_data;
  logic                    s_last;
  logic [7:0]              s_opcode;
  logic [11:0]             s_tag;
  logic [NVME_ENTRY_W-1:0] fifo_data;
  logic                    fifo_wrreq;
  logic                    fifo_wrfull;

  // master is the writer block itself; slave is the beat source plus FIFO
  modport master (
    input  s_valid, s_data, s_last, s_opcode, s_tag, fifo_wrfull,
    output s_ready, fifo_data, fifo_wrreq
  );

  modport slave (
    output s_valid, s_data, s_last, s_opcode, s_tag, fifo_wrfull,
    input  s_ready, fifo_data, fifo_wrreq
  );

endinterface

// File: rtl/nvme_to_fifo_writer_packer.sv
// rtl/nvme_to_fifo_writer_packer.sv - payload lane register file and beat counter (nvme_beat_packer)
module nvme_beat_packer
  import nvme_fifo_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      beat_we,
  input  logic [NVME_BEAT_W-1:0]    beat_data,
  input  logic                      clear,
  output logic [NVME_PAYLOAD_W-1:0] payload,
  output logic [3:0]                count
);

  logic [NVME_BEATS-1:0][NVME_BEAT_W-1:0] lanes_q, lanes_d;
  logic [3:0]                             count_q, count_d;

  always_comb begin
    lanes_d = lanes_q;
    count_d = count_q;
    if (clear) begin
      lanes_d = '0;
      count_d = '0;
    end else if (beat_we && (count_q < 4'(NVME_BEATS))) begin
      lanes_d[count_q[2:0]] = beat_data;
      count_d               = count_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lanes_q <= '0;
      count_q <= '0;
    end else begin
      lanes_q <= lanes_d;
      count_q <= count_d;
    end
  end

  assign payload = lanes_q;
  assign count   = count_q;

endmodule

// File: rtl/nvme_to_fifo_writer.sv
// rtl/nvme_to_fifo_writer.sv - packs 64-bit beats into 540-bit NVMe FIFO entries; NVME_FIFO_WR_STATS_EN adds write/stall counters
module nvme_to_fifo_writer
  import nvme_fifo_pkg::*;
#(
  parameter int DATA_WIDTH      = 540,
  parameter int BEAT_WIDTH      = 64,
  parameter int BEATS_PER_ENTRY = 8
) (
  input  logic                  wrclk,
  input  logic                  aclr_n,
  nvme_to_fifo_writer_if.master bus,
  output logic                  busy
`ifdef NVME_FIFO_WR_STATS_EN
  ,
  output logic [31:0]           entry_count,
  output logic [31:0]           stall_cycles
`endif
);

  if (DATA_WIDTH != NVME_ENTRY_W || BEAT_WIDTH != NVME_BEAT_W ||
      BEATS_PER_ENTRY != NVME_BEATS || $bits(nvme_fifo_hdr_t) != NVME_HDR_W ||
      HDR_OPCODE_LSB != NVME_PAYLOAD_W || HDR_CONT_BIT != NVME_ENTRY_W - 3 ||
      HDR_TAG_LSB != HDR_OPCODE_LSB + 8 || HDR_BEATS_LSB != HDR_TAG_LSB + 12 ||
      HDR_LAST_BIT != HDR_BEATS_LSB + 4) begin : g_bad_cfg
    $error("nvme_to_fifo_writer: entry must be 512 payload + 28 header built from 8 x 64-bit beats");
  end

  nvme_wr_state_e state_q, state_d;
  logic [7:0]     opcode_q, opcode_d;
  logic [11:0]    tag_q, tag_d;
  logic           last_q, last_d;
  logic           cont_q, cont_d;
  logic           in_frame_q, in_frame_d;

  logic                      xfer;
  logic                      entry_done;
  logic                      wr_fire;
  logic [3:0]                beat_cnt;
  logic [NVME_PAYLOAD_W-1:0] payload;
  nvme_fifo_hdr_t            hdr;

  assign xfer       = bus.s_valid && bus.s_ready;
  assign entry_done = xfer && (bus.s_last || beat_cnt == 4'(BEATS_PER_ENTRY - 1));
  assign wr_fire    = bus.fifo_wrreq;

  nvme_beat_packer u_packer (
    .clk       (wrclk),
    .rst_n     (aclr_n),
    .beat_we   (xfer),
    .beat_data (bus.s_data),
    .clear     (wr_fire),
    .payload   (payload),
    .count     (beat_cnt)
  );

  always_ff @(posedge wrclk or negedge aclr_n) begin
    if (!aclr_n) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, COLLECT: begin
        if (entry_done) state_d = WRITE;
        else if (xfer)  state_d = COLLECT;
      end
      WRITE:   if (wr_fire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // s_ready is gated by the reset pin so it is low throughout reset, high right after release
  always_comb begin
    bus.s_ready    = aclr_n && (state_q != WRITE);
    bus.fifo_wrreq = (state_q == WRITE) && !bus.fifo_wrfull;
    busy           = (state_q != IDLE);
  end

  // opcode/tag are only resampled on the first entry of a new frame
  always_comb begin
    opcode_d   = opcode_q;
    tag_d      = tag_q;
    last_d     = last_q;
    cont_d     = cont_q;
    in_frame_d = in_frame_q;
    if (xfer) begin
      last_d = bus.s_last;
      if (state_q == IDLE) begin
        cont_d = in_frame_q;
        if (!in_frame_q) begin
          opcode_d = bus.s_opcode;
          tag_d    = bus.s_tag;
        end
      end
    end
    if (wr_fire) in_frame_d = !last_q;
  end

  always_ff @(posedge wrclk or negedge aclr_n) begin
    if (!aclr_n) begin
      opcode_q   <= '0;
      tag_q      <= '0;
      last_q     <= 1'b0;
      cont_q     <= 1'b0;
      in_frame_q <= 1'b0;
    end else begin
      opcode_q   <= opcode_d;
      tag_q      <= tag_d;
      last_q     <= last_d;
      cont_q     <= cont_d;
      in_frame_q <= in_frame_d;
    end
  end

  always_comb begin
    hdr            = '0;
    hdr.cont       = cont_q;
    hdr.last       = last_q;
    hdr.beats      = beat_cnt;
    hdr.tag        = tag_q;
    hdr.opcode     = opcode_q;
    bus.fifo_data  = nvme_pack_entry(hdr, payload);
  end

`ifdef NVME_FIFO_WR_STATS_EN
  logic [31:0] entry_count_q, entry_count_d;
  logic [31:0] stall_cycles_q, stall_cycles_d;

  always_comb begin
    entry_count_d  = entry_count_q;
    stall_cycles_d = stall_cycles_q;
    if (wr_fire && entry_count_q != '1)
      entry_count_d = entry_count_q + 32'd1;
    if (state_q == WRITE && bus.fifo_wrfull && stall_cycles_q != '1)
      stall_cycles_d = stall_cycles_q + 32'd1;
  end

  always_ff @(posedge wrclk or negedge aclr_n) begin
    if (!aclr_n) begin
      entry_count_q  <= '0;
      stall_cycles_q <= '0;
    end else begin
      entry_count_q  <= entry_count_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign entry_count  = entry_count_q;
  assign stall_cycles = stall_cycles_q;
`endif

endmodule
